// File: rtl/icache_sa.sv
// rtl/icache_sa.sv - set-associative instruction cache with early-restart line fill
// Ports:
//   clk, rst            : clock, asynchronous active-low reset
//   en                  : global enable, all state holds while low
//   iIF_En, iIF_Pc      : fetch request and word-aligned byte address
//   oIF_Rdy             : request can be accepted this cycle
//   oIF_En, oIF_Ins     : instruction return pulse and word
//   oBP_En, oBP_Ins     : copy of the instruction return for the branch predictor
//   iFlush, iClr        : invalidate everything / cancel the pending fetch
//   oMC_En, oMC_Addr    : line-fill request pulse and line base address
//   iMC_En, iMC_Ins     : fill words, delivered in line order
//   oHitCnt, oMissCnt   : saturating hit / miss counters
module icache_sa #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int SETS       = 16,
   parameter int WAYS       = 2,
   parameter int LINE_WORDS = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              iIF_En,
   input  logic [ADDR_W-1:0] iIF_Pc,
   output logic              oIF_Rdy,
   output logic              oIF_En,
   output logic [DATA_W-1:0] oIF_Ins,
   output logic              oBP_En,
   output logic [DATA_W-1:0] oBP_Ins,
   input  logic              iFlush,
   input  logic              iClr,
   output logic              oMC_En,
   output logic [ADDR_W-1:0] oMC_Addr,
   input  logic              iMC_En,
   input  logic [DATA_W-1:0] iMC_Ins,
   output logic [31:0]       oHitCnt,
   output logic [31:0]       oMissCnt
);

   localparam int OFF_W = $clog2(LINE_WORDS);
   localparam int IDX_W = $clog2(SETS);
   localparam int TAG_W = ADDR_W - OFF_W - IDX_W - 2;
   localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

   typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;

   state_t state_q, state_d;

   logic [SETS-1:0][WAYS-1:0]  valid_q;
   logic [SETS-1:0][WAY_W-1:0] rr_q;
   logic [TAG_W-1:0]           tag_q  [SETS][WAYS];
   logic [DATA_W-1:0]          data_q [SETS][WAYS][LINE_WORDS];

   // Outstanding fill: where it goes and which word the fetch is waiting on
   logic [IDX_W-1:0] req_idx_q;
   logic [OFF_W-1:0] req_off_q;
   logic [TAG_W-1:0] req_tag_q;
   logic [WAY_W-1:0] vic_q;
   logic [OFF_W-1:0] k_q;
   logic             keep_q;    // cleared by a flush so the aborted line is never validated

   logic [OFF_W-1:0] pc_off;
   logic [IDX_W-1:0] pc_idx;
   logic [TAG_W-1:0] pc_tag;
   logic             unused_pc;

   logic             hit;
   logic [WAY_W-1:0] hit_way;
   logic [WAY_W-1:0] victim;

   logic do_hit, do_miss, mc_word, last_word, deliver, commit;

   assign pc_off    = iIF_Pc[OFF_W+1:2];
   assign pc_idx    = iIF_Pc[OFF_W+IDX_W+1:OFF_W+2];
   assign pc_tag    = iIF_Pc[ADDR_W-1:OFF_W+IDX_W+2];
   assign unused_pc = ^iIF_Pc[1:0];

   assign oIF_Rdy = (state_q == IDLE);
   assign oBP_En  = oIF_En;
   assign oBP_Ins = oIF_Ins;

   // Tag compare and victim choice; descending scans leave the lowest-numbered match
   always_comb begin
      hit     = 1'b0;
      hit_way = '0;
      victim  = rr_q[pc_idx];
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (valid_q[pc_idx][w] && (tag_q[pc_idx][w] == pc_tag)) begin
            hit     = 1'b1;
            hit_way = WAY_W'(w);
         end
         if (!valid_q[pc_idx][w]) begin
            victim = WAY_W'(w);
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      do_hit    = 1'b0;
      do_miss   = 1'b0;
      mc_word   = 1'b0;
      last_word = 1'b0;
      deliver   = 1'b0;
      commit    = 1'b0;
      case (state_q)
         IDLE: begin
            // A request coinciding with flush/clear is dropped outright
            if (iIF_En && !iFlush && !iClr) begin
               if (hit) begin
                  do_hit = 1'b1;
               end else begin
                  do_miss = 1'b1;
                  state_d = FILL;
               end
            end
         end
         FILL, DRAIN: begin
            mc_word   = iMC_En;
            last_word = iMC_En && (k_q == {OFF_W{1'b1}});
            deliver   = (state_q == FILL) && iMC_En && (k_q == req_off_q) && !iFlush && !iClr;
            commit    = last_word && keep_q && !iFlush;
            if (last_word) begin
               state_d = IDLE;
            end else if ((state_q == FILL) && (iFlush || iClr)) begin
               state_d = DRAIN;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         valid_q   <= '0;
         rr_q      <= '0;
         req_idx_q <= '0;
         req_off_q <= '0;
         req_tag_q <= '0;
         vic_q     <= '0;
         k_q       <= '0;
         keep_q    <= 1'b0;
         oIF_En    <= 1'b0;
         oIF_Ins   <= '0;
         oMC_En    <= 1'b0;
         oMC_Addr  <= '0;
         oHitCnt   <= '0;
         oMissCnt  <= '0;
      end else if (en) begin
         state_q <= state_d;
         oIF_En  <= 1'b0;
         oMC_En  <= 1'b0;

         if (do_hit) begin
            oIF_En  <= 1'b1;
            oIF_Ins <= data_q[pc_idx][hit_way][pc_off];
            if (oHitCnt != 32'hFFFF_FFFF) oHitCnt <= oHitCnt + 32'd1;
         end

         if (do_miss) begin
            // Invalidate the victim now so the partially written line cannot hit
            valid_q[pc_idx][victim] <= 1'b0;
            req_idx_q <= pc_idx;
            req_off_q <= pc_off;
            req_tag_q <= pc_tag;
            vic_q     <= victim;
            k_q       <= '0;
            keep_q    <= 1'b1;
            oMC_En    <= 1'b1;
            oMC_Addr  <= {iIF_Pc[ADDR_W-1:OFF_W+2], {(OFF_W+2){1'b0}}};
            if (oMissCnt != 32'hFFFF_FFFF) oMissCnt <= oMissCnt + 32'd1;
         end

         if (mc_word) begin
            k_q <= k_q + OFF_W'(1);
         end

         if (deliver) begin
            oIF_En  <= 1'b1;
            oIF_Ins <= iMC_Ins;
         end

         if (commit) begin
            valid_q[req_idx_q][vic_q] <= 1'b1;
            rr_q[req_idx_q] <= (rr_q[req_idx_q] == WAY_W'(WAYS - 1)) ? '0
                               : rr_q[req_idx_q] + WAY_W'(1);
         end

         if (iFlush) begin
            valid_q <= '0;
            rr_q    <= '0;
            keep_q  <= 1'b0;
         end
      end
   end

   // Line storage carries no reset; validity alone decides what can hit
   always_ff @(posedge clk) begin
      if (en && mc_word) data_q[req_idx_q][vic_q][k_q] <= iMC_Ins;
      if (en && commit)  tag_q[req_idx_q][vic_q]       <= req_tag_q;
   end

endmodule

// File: tb/tb_icache_sa.sv
// tb/tb_icache_sa.sv - randomized self-checking bench for icache_sa
module tb_icache_sa;
   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int SETS   = 16;
   localparam int WAYS   = 2;
   localparam int LW     = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        en = 1'b0;
   logic        iIF_En = 1'b0;
   logic [31:0] iIF_Pc = '0;
   logic        iFlush = 1'b0;
   logic        iClr = 1'b0;
   logic        iMC_En = 1'b0;
   logic [31:0] iMC_Ins = '0;
   logic        oIF_Rdy, oIF_En, oBP_En, oMC_En;
   logic [31:0] oIF_Ins, oBP_Ins, oMC_Addr, oHitCnt, oMissCnt;

   always #5 clk = ~clk;

   icache_sa #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SETS(SETS), .WAYS(WAYS), .LINE_WORDS(LW)) dut (
      .clk(clk), .rst(rst), .en(en),
      .iIF_En(iIF_En), .iIF_Pc(iIF_Pc),
      .oIF_Rdy(oIF_Rdy), .oIF_En(oIF_En), .oIF_Ins(oIF_Ins),
      .oBP_En(oBP_En), .oBP_Ins(oBP_Ins),
      .iFlush(iFlush), .iClr(iClr),
      .oMC_En(oMC_En), .oMC_Addr(oMC_Addr),
      .iMC_En(iMC_En), .iMC_Ins(iMC_Ins),
      .oHitCnt(oHitCnt), .oMissCnt(oMissCnt)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: whole lines keyed by base address, data committed on completion
   bit          m_valid [SETS][WAYS];
   logic [31:0] m_line  [SETS][WAYS];
   logic [31:0] m_data  [SETS][WAYS][LW];
   int          m_rr    [SETS];
   logic [31:0] m_buf   [LW];
   bit          m_busy, m_want, m_keep;
   int          m_got, m_set, m_way, m_off;
   logic [31:0] m_base;

   bit          e_rdy, e_ifen, e_mcen, n_rdy, n_ifen, n_mcen;
   logic [31:0] e_ins, e_addr, e_hit, e_miss, n_ins, n_addr, n_hit, n_miss;
   bit          chk_on = 1'b0;

   task automatic model_reset();
      for (int s = 0; s < SETS; s++) begin
         m_rr[s] = 0;
         for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
      end
      m_busy = 1'b0; m_want = 1'b0; m_keep = 1'b0; m_got = 0;
      e_rdy = 1'b1; e_ifen = 1'b0; e_mcen = 1'b0;
      e_ins = '0; e_addr = '0; e_hit = '0; e_miss = '0;
   endtask

   task automatic model_step(input bit e, input bit ife, input logic [31:0] pc, input bit fl,
                             input bit cl, input bit mce, input logic [31:0] mcd);
      int s, off, hw, v;
      logic [31:0] base;
      n_rdy = e_rdy; n_ifen = e_ifen; n_ins = e_ins; n_mcen = e_mcen;
      n_addr = e_addr; n_hit = e_hit; n_miss = e_miss;
      if (!e) return;
      n_ifen = 1'b0;
      n_mcen = 1'b0;
      if (!m_busy) begin
         if (ife && !fl && !cl) begin
            base = pc - (pc % (LW * 4));
            s    = int'((pc / (LW * 4)) % SETS);
            off  = int'((pc / 4) % LW);
            hw   = -1;
            for (int w = 0; w < WAYS; w++)
               if (m_valid[s][w] && m_line[s][w] == base) hw = w;
            if (hw >= 0) begin
               n_ifen = 1'b1;
               n_ins  = m_data[s][hw][off];
               if (n_hit != 32'hFFFF_FFFF) n_hit++;
            end else begin
               v = m_rr[s];
               for (int w = WAYS - 1; w >= 0; w--) if (!m_valid[s][w]) v = w;
               m_valid[s][v] = 1'b0;
               m_busy = 1'b1; m_want = 1'b1; m_keep = 1'b1; m_got = 0;
               m_set = s; m_way = v; m_off = off; m_base = base;
               n_mcen = 1'b1;
               n_addr = base;
               if (n_miss != 32'hFFFF_FFFF) n_miss++;
            end
         end
      end else if (mce) begin
         m_buf[m_got] = mcd;
         if (m_want && m_got == m_off && !fl && !cl) begin
            n_ifen = 1'b1;
            n_ins  = mcd;
         end
         m_got++;
         if (m_got == LW) begin
            m_busy = 1'b0;
            if (m_keep && !fl) begin
               for (int k = 0; k < LW; k++) m_data[m_set][m_way][k] = m_buf[k];
               m_valid[m_set][m_way] = 1'b1;
               m_line[m_set][m_way]  = m_base;
               m_rr[m_set] = (m_rr[m_set] + 1) % WAYS;
            end
         end
      end
      if (m_busy && (fl || cl)) m_want = 1'b0;
      if (fl) begin
         m_keep = 1'b0;
         for (int s2 = 0; s2 < SETS; s2++) begin
            m_rr[s2] = 0;
            for (int w = 0; w < WAYS; w++) m_valid[s2][w] = 1'b0;
         end
      end
      n_rdy = !m_busy;
   endtask

   task automatic cyc(input bit e, input bit ife, input logic [31:0] pc, input bit fl,
                      input bit cl, input bit mce, input logic [31:0] mcd);
      en = e; iIF_En = ife; iIF_Pc = pc; iFlush = fl; iClr = cl; iMC_En = mce; iMC_Ins = mcd;
      model_step(e, ife, pc, fl, cl, mce, mcd);
      @(posedge clk);
      #1;
      e_rdy = n_rdy; e_ifen = n_ifen; e_ins = n_ins; e_mcen = n_mcen;
      e_addr = n_addr; e_hit = n_hit; e_miss = n_miss;
   endtask

   task automatic idle();
      cyc(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
   endtask

   task automatic req(input logic [31:0] pc);
      cyc(1'b1, 1'b1, pc, 1'b0, 1'b0, 1'b0, '0);
   endtask

   task automatic feed(input logic [31:0] first, input int n);
      for (int k = 0; k < n; k++) cyc(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b1, first + 32'(k));
   endtask

   always @(negedge clk) begin
      if (chk_on) begin
         chk("rdy", {31'b0, oIF_Rdy}, {31'b0, e_rdy});
         chk("if_en", {31'b0, oIF_En}, {31'b0, e_ifen});
         chk("bp_en", {31'b0, oBP_En}, {31'b0, e_ifen});
         if (e_ifen) begin
            chk("if_ins", oIF_Ins, e_ins);
            chk("bp_ins", oBP_Ins, e_ins);
         end
         chk("mc_en", {31'b0, oMC_En}, {31'b0, e_mcen});
         if (e_mcen) chk("mc_addr", oMC_Addr, e_addr);
         chk("hit_cnt", oHitCnt, e_hit);
         chk("miss_cnt", oMissCnt, e_miss);
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      bit          r_e, r_fl, r_cl, r_ife, r_mce;
      logic [31:0] r_pc, hb, mb;

      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("reset_rdy", {31'b0, oIF_Rdy}, 32'd1);
      chk("reset_if_en", {31'b0, oIF_En}, 32'd0);
      chk("reset_mc_en", {31'b0, oMC_En}, 32'd0);
      chk("reset_hits", oHitCnt, 32'd0);
      chk("reset_misses", oMissCnt, 32'd0);
      rst = 1'b1;
      chk_on = 1'b1;

      // Cold miss with early restart on word 1, then a hit on word 3
      req(32'h104);
      chk("cold_mc_en", {31'b0, oMC_En}, 32'd1);
      chk("cold_mc_addr", oMC_Addr, 32'h100);
      feed(32'hA0, 2);
      chk("early_en", {31'b0, oIF_En}, 32'd1);
      chk("early_ins", oIF_Ins, 32'hA1);
      feed(32'hA2, 1);
      chk("fill_busy", {31'b0, oIF_Rdy}, 32'd0);
      feed(32'hA3, 1);
      chk("fill_done_rdy", {31'b0, oIF_Rdy}, 32'd1);
      req(32'h10C);
      chk("hit_en", {31'b0, oIF_En}, 32'd1);
      chk("hit_ins", oIF_Ins, 32'hA3);
      chk("hit_count", oHitCnt, 32'd1);
      chk("miss_count", oMissCnt, 32'd1);

      // Associativity: three lines into set 0 of a 2-way cache
      cyc(1'b1, 1'b0, '0, 1'b1, 1'b0, 1'b0, '0);
      req(32'h000); feed(32'h10, LW);
      req(32'h400); feed(32'h20, LW);
      req(32'h800); feed(32'h30, LW);
      req(32'h400);
      chk("assoc_keep_en", {31'b0, oIF_En}, 32'd1);
      chk("assoc_keep_ins", oIF_Ins, 32'h20);
      req(32'h000);
      chk("assoc_evict_miss", {31'b0, oMC_En}, 32'd1);
      feed(32'h40, LW);

      // Cancel right after a miss: no return, but the line still lands
      req(32'h204);
      cyc(1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b0, '0);
      feed(32'h50, LW);
      chk("clr_rdy", {31'b0, oIF_Rdy}, 32'd1);
      req(32'h204);
      chk("clr_then_hit", {31'b0, oIF_En}, 32'd1);
      chk("clr_then_ins", oIF_Ins, 32'h51);

      // Flush mid-fill: drain completes, nothing stays cached
      req(32'h300);
      feed(32'h60, 1);
      cyc(1'b1, 1'b0, '0, 1'b1, 1'b0, 1'b0, '0);
      feed(32'h61, LW - 1);
      chk("flush_drain_rdy", {31'b0, oIF_Rdy}, 32'd1);
      req(32'h300);
      chk("flush_miss_300", {31'b0, oMC_En}, 32'd1);
      feed(32'h70, LW);
      req(32'h100);
      chk("flush_miss_100", {31'b0, oMC_En}, 32'd1);
      feed(32'h80, LW);

      // Flush together with a request that would hit
      hb = e_hit;
      mb = e_miss;
      cyc(1'b1, 1'b1, 32'h100, 1'b1, 1'b0, 1'b0, '0);
      chk("drop_if_en", {31'b0, oIF_En}, 32'd0);
      chk("drop_mc_en", {31'b0, oMC_En}, 32'd0);
      chk("drop_hits", oHitCnt, hb);
      chk("drop_misses", oMissCnt, mb);
      req(32'h300);
      chk("drop_invalidated", {31'b0, oMC_En}, 32'd1);
      feed(32'h90, LW);

      // Enable low mid-fill with the early-restart pulse showing
      req(32'h504);
      feed(32'hB0, 2);
      repeat (3) cyc(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
      chk("en_hold_if_en", {31'b0, oIF_En}, 32'd1);
      chk("en_hold_ins", oIF_Ins, 32'hB1);
      chk("en_hold_rdy", {31'b0, oIF_Rdy}, 32'd0);
      feed(32'hB2, 2);
      chk("en_resume_rdy", {31'b0, oIF_Rdy}, 32'd1);
      req(32'h50C);
      chk("en_resume_ins", oIF_Ins, 32'hB3);

      // Asynchronous reset in the middle of a fill
      req(32'h604);
      feed(32'hC0, 1);
      #2;
      chk_on = 1'b0;
      rst = 1'b0; en = 1'b1; iIF_En = 1'b0; iFlush = 1'b0; iClr = 1'b0; iMC_En = 1'b0;
      #1;
      chk("async_rdy", {31'b0, oIF_Rdy}, 32'd1);
      chk("async_hits", oHitCnt, 32'd0);
      chk("async_misses", oMissCnt, 32'd0);
      model_reset();
      @(posedge clk);
      #1;
      iMC_En = 1'b1;
      iMC_Ins = 32'hC1;
      @(posedge clk);
      #3;
      iMC_En = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk_on = 1'b1;
      cyc(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b1, 32'hDEAD);
      req(32'h104);
      chk("after_reset_miss", {31'b0, oMC_En}, 32'd1);
      feed(32'hD0, LW);

      // Randomized traffic over a small address pool to force reuse and conflicts
      for (int i = 0; i < 4000; i++) begin
         r_e   = ($urandom % 8) != 0;
         r_fl  = ($urandom % 60) == 0;
         r_cl  = ($urandom % 20) == 0;
         r_pc  = (($urandom % 6) << 8) | (($urandom % 3) << 4) | (($urandom % LW) << 2);
         r_ife = m_busy ? (($urandom % 8) == 0) : (($urandom % 2) == 0);
         r_mce = r_e && m_busy && (($urandom % 3) != 0);
         cyc(r_e, r_ife, r_pc, r_fl, r_cl, r_mce, $urandom);
      end
      for (int g = 0; g < LW && m_busy; g++) cyc(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b1, $urandom);
      idle();
      idle();
      chk_on = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/icache_sa.md
Name: icache_sa

Overview:
- Parametrised set-associative instruction cache with multi-word lines. Sits between the instruction fetch stage (IF) and the memory controller (MC), and mirrors fetched instructions to the branch predictor (BP).
- Supersedes the direct-mapped single-word cache. Adds configurable ways, sets and line length, per-set replacement, early-restart line fill, full flush, and request cancel with memory drain.

Parameters:
ADDR_W, 32, byte address width
DATA_W, 32, instruction/word width
SETS, 16, number of sets (power of 2, >=2)
WAYS, 2, associativity (1, 2 or 4)
LINE_WORDS, 4, words per line (power of 2, >=2)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
en  in  1  global enable; when low, all state and outputs hold
iIF_En  in  1  fetch request, single-cycle pulse, valid only while oIF_Rdy=1
iIF_Pc  in  ADDR_W  fetch byte address, word aligned
oIF_Rdy  out  1  cache can accept a request this cycle
oIF_En  out  1  instruction valid, one-cycle pulse
oIF_Ins  out  DATA_W  instruction
oBP_En  out  1  mirror of oIF_En
oBP_Ins  out  DATA_W  mirror of oIF_Ins
iFlush  in  1  invalidate all lines; abort pending fetch
iClr  in  1  cancel pending fetch (misprediction); cache contents kept
oMC_En  out  1  line-fill request, one-cycle pulse
oMC_Addr  out  ADDR_W  line base address
iMC_En  in  1  fill word valid
iMC_Ins  in  DATA_W  fill word; words arrive in order 0..LINE_WORDS-1
oHitCnt  out  32  saturating hit counter
oMissCnt  out  32  saturating miss counter

Behaviour:
- Address split:
  - offset = Pc[log2(LINE_WORDS)+1:2]
  - index = next log2(SETS) bits
  - tag = remaining upper bits
  - Pc[1:0] ignored.
- Reset values (rst low, asynchronous):
  - all valid bits 0, replacement pointers 0, counters 0
  - all outputs 0, except oIF_Rdy=1
  - state IDLE.
- States: IDLE, FILL, DRAIN.
- IDLE, iIF_En=1 at cycle T:
  - Hit (any way valid with matching tag): oIF_En=oBP_En=1 at T+1 with the word; oHitCnt+1; stay IDLE; oIF_Rdy stays 1.
  - Miss: oMC_En=1 at T+1 with oMC_Addr = Pc with offset and low 2 bits zeroed; oMissCnt+1; oIF_Rdy=0 from T+1; go to FILL.
- Victim way:
  - lowest-numbered invalid way in the set;
  - otherwise the set's round-robin pointer, which advances (mod WAYS) on each completed fill into that set.
- FILL:
  - Word counter k counts iMC_En pulses.
  - Word k is written into the victim data array.
  - When k equals the requested offset at cycle M, oIF_En/oBP_En=1 at M+1 with that word (early restart).
  - When the last word (k=LINE_WORDS-1) arrives at cycle L:
    - the victim line becomes valid with the new tag at L+1;
    - state is IDLE and oIF_Rdy=1 at L+1.
  - The victim's valid bit is cleared at the miss cycle, so a partial line never hits.
- iClr in FILL:
  - Go to DRAIN and suppress the pending oIF_En if not yet sent.
  - Remaining words are still written; the line is validated at completion as normal.
- iFlush (any state):
  - All valid bits and pointers are cleared the next cycle.
  - In FILL: go to DRAIN, suppress output, and do not validate the line being filled.
- DRAIN:
  - Accept remaining iMC_En words up to LINE_WORDS total; no IF output.
  - Return to IDLE after the last word.
  - oMC_En is never issued in DRAIN.
- Simultaneous events:
  - iFlush or iClr with iIF_En in the same cycle: the request is dropped (no output, no counter change). iFlush also invalidates.
  - iFlush and iClr together: iFlush behaviour.
  - iIF_En while oIF_Rdy=0: ignored.
- Counters: saturate at 2^32-1.
- en low:
  - nothing updates and registered outputs hold.
  - The MC shares en, so no iMC_En arrives while en is low.
- Reset mid-fill: immediate return to IDLE with everything invalid. Fill words arriving after reset are ignored.

Test Plan:
- Cold miss, defaults: Pc=0x104 → oMC_En pulse with oMC_Addr=0x100. Feed words 0xA0..0xA3 → oIF_Ins=0xA1 one cycle after the 2nd word. oIF_Rdy=1 one cycle after the 4th word. Then Pc=0x10C → hit with 0xA3 in 1 cycle; oHitCnt=1, oMissCnt=1.
- Associativity: fill 0x000, 0x400 and 0x800, all set 0. Third fill evicts way 0 (0x000); 0x400 still hits, 0x000 misses.
- iClr one cycle after miss on 0x204 → no oIF_En. After 4 words, IDLE; 0x204 then hits.
- iFlush mid-fill on 0x300 → no oIF_En; drain of 4 words completes. Subsequent 0x300 and previously cached 0x100 both miss.
- Same-cycle iFlush+iIF_En in IDLE → no output, counters unchanged, all lines invalid.
- en held low for 3 cycles mid-fill → outputs frozen. Resume completes correctly. Async rst low mid-fill → oIF_Rdy=1 and counters 0 immediately.
